// File: rtl/mem_resp_pkg.sv
// Shared widths, FSM state encoding and the captured-request bundle
// for the mem_responder slice.
package mem_resp_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    DONE
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              wr;
  } req_t;

endpackage

// File: rtl/mem_array.sv
// 32x8 storage: one synchronous write port, one combinational read
// port. Contents are never reset.
module mem_array
  import mem_resp_pkg::*;
(
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder with preload port and level strobes.
// Optional write protection below WP_LIMIT: define MEM_WPROT_EN.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int                WAIT_STATES = 1,
  parameter logic [ADDR_W-1:0] WP_LIMIT    = 5'h10
) (
  input  logic              clock,
  input  logic              rst_,
  input  logic [ADDR_W-1:0] addr,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] data_in,
  output logic              ready,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              acc_err,
  output logic              wp_err
);

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  state_t            state;
  logic [2:0]        cnt;
  req_t              lat;
  logic              wp_hit;
  logic              ld_go;
  logic              cpu_wr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              capture;

`ifdef MEM_WPROT_EN
  assign wp_hit = lat.addr < WP_LIMIT;
`else
  logic unused_wp;
  assign unused_wp = ^WP_LIMIT;
  assign wp_hit    = 1'b0;
`endif

  // rst_ gates both write sources so an aborted access never lands
  assign ld_go  = (state == IDLE) && ld_en && rst_;
  assign cpu_wr = (state == RESP) && lat.wr && !wp_hit && rst_;

  assign mem_we    = ld_go || cpu_wr;
  assign mem_waddr = ld_go ? ld_addr : lat.addr;
  assign mem_wdata = ld_go ? ld_data : lat.data;

  assign capture = (state == IDLE) && !ld_en && (read ^ write);

  mem_array u_mem (
    .clock (clock),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (lat.addr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clock) begin
    if (capture) begin
      lat.addr <= addr;
      lat.data <= data_out;
      lat.wr   <= write;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      ready   <= 1'b0;
      data_in <= '0;
      acc_err <= 1'b0;
      wp_err  <= 1'b0;
    end else begin
      ready  <= 1'b0;
      wp_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!ld_en && read && write) begin
            acc_err <= 1'b1;
          end else if (capture) begin
            cnt   <= 3'd0;
            state <= (WS == 3'd0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt == WS - 3'd1) state <= RESP;
          else                  cnt   <= cnt + 3'd1;
        end
        RESP: begin
          ready  <= 1'b1;
          wp_err <= lat.wr && wp_hit;
          if (!lat.wr) data_in <= mem_rdata;
          state  <= DONE;
        end
        DONE: begin
          if (!read && !write) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: instance 0 with one wait state,
// instance 1 with zero wait states.
module tb_mem_responder;

  logic       clock = 1'b0;
  logic       rst_;
  logic [4:0] addr [2];
  logic [1:0] rd;
  logic [1:0] wr;
  logic [1:0] ld;
  logic [7:0] dout [2];
  logic [4:0] la [2];
  logic [7:0] ldd [2];
  logic [7:0] din [2];
  logic [1:0] rdy;
  logic [1:0] aerr;
  logic [1:0] wperr;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  mem_responder #(.WAIT_STATES(1)) u_ws1 (
    .clock    (clock),
    .rst_     (rst_),
    .addr     (addr[0]),
    .read     (rd[0]),
    .write    (wr[0]),
    .data_out (dout[0]),
    .data_in  (din[0]),
    .ready    (rdy[0]),
    .ld_en    (ld[0]),
    .ld_addr  (la[0]),
    .ld_data  (ldd[0]),
    .acc_err  (aerr[0]),
    .wp_err   (wperr[0])
  );

  mem_responder #(.WAIT_STATES(0)) u_ws0 (
    .clock    (clock),
    .rst_     (rst_),
    .addr     (addr[1]),
    .read     (rd[1]),
    .write    (wr[1]),
    .data_out (dout[1]),
    .data_in  (din[1]),
    .ready    (rdy[1]),
    .ld_en    (ld[1]),
    .ld_addr  (la[1]),
    .ld_data  (ldd[1]),
    .acc_err  (aerr[1]),
    .wp_err   (wperr[1])
  );

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(int s, logic [4:0] a, logic [7:0] d);
    ld[s]  = 1'b1;
    la[s]  = a;
    ldd[s] = d;
    tick();
    ld[s]  = 1'b0;
  endtask

  // lat = ticks after the capture edge until ready is seen
  task automatic access(int s, bit w, logic [4:0] a,
                        logic [7:0] d, int hold,
                        output int lat, output int np,
                        output int nwp);
    lat = -1;
    np  = 0;
    nwp = 0;
    addr[s] = a;
    dout[s] = d;
    if (w) wr[s] = 1'b1;
    else   rd[s] = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (rdy[s]) begin
        if (lat < 0) lat = i;
        np++;
        if (wperr[s]) nwp++;
      end
    end
    rd[s] = 1'b0;
    wr[s] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (rdy[s]) np++;
    end
  endtask

  task automatic rd_chk(int s, logic [4:0] a, logic [7:0] exp,
                        string tag);
    int lat, np, nwp;
    access(s, 1'b0, a, 8'h00, 6, lat, np, nwp);
    check({tag, "_np"}, np, 1);
    check(tag, din[s], exp);
  endtask

  initial begin
    int lat, np, nwp;
    rst_ = 1'b0;
    rd = '0;
    wr = '0;
    ld = '0;
    for (int s = 0; s < 2; s++) begin
      addr[s] = '0;
      dout[s] = '0;
      la[s]   = '0;
      ldd[s]  = '0;
    end
    tick();
    tick();
    check("rst_ready", rdy, 2'b00);
    check("rst_din0", din[0], 8'h00);
    check("rst_din1", din[1], 8'h00);
    check("rst_acc", aerr, 2'b00);
    check("rst_wp", wperr, 2'b00);
    rst_ = 1'b1;
    tick();

    preload(0, 5'h1B, 8'h90);
    access(0, 1'b0, 5'h1B, 8'h00, 6, lat, np, nwp);
    check("ws1_lat", lat, 2);
    check("ws1_np", np, 1);
    check("ws1_din", din[0], 8'h90);
    tick();
    tick();
    check("din_hold", din[0], 8'h90);

    access(1, 1'b1, 5'h1A, 8'h55, 4, lat, np, nwp);
    check("ws0_wr_lat", lat, 1);
    check("ws0_wr_np", np, 1);
    access(1, 1'b0, 5'h1A, 8'h00, 4, lat, np, nwp);
    check("ws0_rd_lat", lat, 1);
    check("ws0_rd_din", din[1], 8'h55);

    access(0, 1'b1, 5'h1F, 8'hA5, 6, lat, np, nwp);
    check("a1f_np", np, 1);
    rd_chk(0, 5'h1F, 8'hA5, "a1f_rd");

    preload(0, 5'h03, 8'h3C);
    addr[0] = 5'h03;
    dout[0] = 8'hEE;
    rd[0] = 1'b1;
    wr[0] = 1'b1;
    np = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rdy[0]) np++;
    end
    check("both_np", np, 0);
    check("both_acc", aerr[0], 1'b1);
    rd[0] = 1'b0;
    wr[0] = 1'b0;
    tick();
    rd_chk(0, 5'h03, 8'h3C, "both_mem");
    check("acc_sticky", aerr[0], 1'b1);

    preload(0, 5'h0B, 8'h00);
    addr[0] = 5'h0A;
    dout[0] = 8'h5A;
    wr[0] = 1'b1;
    tick();
    addr[0] = 5'h0B;
    dout[0] = 8'hFF;
    preload(0, 5'h0B, 8'h99);
    tick();
    check("chg_ready", rdy[0], 1'b1);
    wr[0] = 1'b0;
    tick();
    tick();
    rd_chk(0, 5'h0A, 8'h5A, "chg_a");
    rd_chk(0, 5'h0B, 8'h00, "chg_b");

    preload(0, 5'h1D, 8'h77);
    addr[0] = 5'h1D;
    dout[0] = 8'hEE;
    wr[0] = 1'b1;
    tick();
    rst_ = 1'b0;
    tick();
    check("rw_ready", rdy[0], 1'b0);
    rst_ = 1'b1;
    wr[0] = 1'b0;
    tick();
    check("rw_ready2", rdy[0], 1'b0);
    check("rw_din", din[0], 8'h00);
    check("rw_acc", aerr[0], 1'b0);
    rd_chk(0, 5'h1D, 8'h77, "rw_mem");

    preload(0, 5'h1C, 8'h44);
    addr[0] = 5'h1C;
    dout[0] = 8'hBB;
    wr[0] = 1'b1;
    tick();
    tick();
    rst_ = 1'b0;
    tick();
    check("rr_ready", rdy[0], 1'b0);
    rst_ = 1'b1;
    wr[0] = 1'b0;
    tick();
    check("rr_ready2", rdy[0], 1'b0);
    rd_chk(0, 5'h1C, 8'h44, "rr_mem");

    ld[0]   = 1'b1;
    la[0]   = 5'h0E;
    ldd[0]  = 8'hC3;
    addr[0] = 5'h0E;
    rd[0]   = 1'b1;
    tick();
    ld[0] = 1'b0;
    lat = -1;
    np = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rdy[0]) begin
        if (lat < 0) lat = i;
        np++;
      end
    end
    rd[0] = 1'b0;
    tick();
    tick();
    check("ldrd_lat", lat, 2);
    check("ldrd_np", np, 1);
    check("ldrd_din", din[0], 8'hC3);

    preload(0, 5'h05, 8'h11);
    access(0, 1'b1, 5'h05, 8'hAA, 6, lat, np, nwp);
    check("wp_np", np, 1);
`ifdef MEM_WPROT_EN
    check("wp_pulse", nwp, 1);
    rd_chk(0, 5'h05, 8'h11, "wp_mem");
    preload(0, 5'h05, 8'h22);
    rd_chk(0, 5'h05, 8'h22, "wp_ld");
`else
    check("wp_pulse", nwp, 0);
    rd_chk(0, 5'h05, 8'hAA, "wp_mem");
`endif
    check("wp_idle", wperr, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
